ifft8_serial: RTL and testbench

//  8-point radix-2 DIT inverse FFT; return path for the 8-point FFT datapath.

---
 rtl/ifft8_serial.sv | 175 +++++++++++++++++
 tb/tb_ifft8_serial.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_serial.sv
// 8-point radix-2 DIT inverse FFT: serial load, 12 single-butterfly compute cycles, serial unload.
// Define IFFT_STAGE_SCALE_EN for a per-stage >>1 (1/8 total); default is unscaled with saturation.
module ifft8_serial #(
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [2:0]               out_index,
  output logic                     out_last,
  output logic                     busy
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW_FRAC - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t state, state_nxt;

  logic [3:0] cnt;
  logic signed [DATA_W-1:0] mem_r [8];
  logic signed [DATA_W-1:0] mem_i [8];

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (&v[SW-1:DATA_W-1] || ~|v[SW-1:DATA_W-1]) return v[DATA_W-1:0];
    return v[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // butterfly addressing: stage in cnt[3:2], butterfly in cnt[1:0]
  logic [1:0] bfly, mm;
  logic [2:0] pa, qa;
  logic signed [DATA_W-1:0] wr, wi, pr, pi, qr, qi, tr, ti;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] acc_r, acc_i;
  logic signed [DATA_W:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [DATA_W-1:0] np_r, np_i, nq_r, nq_i;
  logic [2:0] nxt_idx;

  always_comb begin
    bfly = cnt[1:0];
    pa = {bfly, 1'b0};
    qa = {bfly, 1'b1};
    mm = 2'd0;
    case (cnt[3:2])
      2'd0: ;
      2'd1: begin
        pa = {bfly[1], 1'b0, bfly[0]};
        qa = {bfly[1], 1'b1, bfly[0]};
        mm = {bfly[0], 1'b0};
      end
      default: begin
        pa = {1'b0, bfly};
        qa = {1'b1, bfly};
        mm = bfly;
      end
    endcase
    // conj(W8^m) for the inverse transform
    wr = DATA_W'(16384);
    wi = DATA_W'(0);
    case (mm)
      2'd1:    begin wr = DATA_W'(11585);  wi = DATA_W'(11585); end
      2'd2:    begin wr = DATA_W'(0);      wi = DATA_W'(16384); end
      2'd3:    begin wr = DATA_W'(-11585); wi = DATA_W'(11585); end
      default: ;
    endcase
    pr = mem_r[pa];
    pi = mem_i[pa];
    qr = mem_r[qa];
    qi = mem_i[qa];
    p_rr = PW'(qr) * PW'(wr);
    p_ii = PW'(qi) * PW'(wi);
    p_ri = PW'(qr) * PW'(wi);
    p_ir = PW'(qi) * PW'(wr);
    acc_r = SW'(p_rr) - SW'(p_ii) + RND;
    acc_i = SW'(p_ri) + SW'(p_ir) + RND;
    tr = sat(acc_r >>> TW_FRAC);
    ti = sat(acc_i >>> TW_FRAC);
    sum_r = (DATA_W+1)'(pr) + (DATA_W+1)'(tr);
    sum_i = (DATA_W+1)'(pi) + (DATA_W+1)'(ti);
    dif_r = (DATA_W+1)'(pr) - (DATA_W+1)'(tr);
    dif_i = (DATA_W+1)'(pi) - (DATA_W+1)'(ti);
`ifdef IFFT_STAGE_SCALE_EN
    np_r = sum_r[DATA_W:1];
    np_i = sum_i[DATA_W:1];
    nq_r = dif_r[DATA_W:1];
    nq_i = dif_i[DATA_W:1];
`else
    np_r = sat(SW'(sum_r));
    np_i = sat(SW'(sum_i));
    nq_r = sat(SW'(dif_r));
    nq_i = sat(SW'(dif_i));
`endif
    nxt_idx = out_index + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && cnt == 4'd7) state_nxt = COMPUTE;
      end
      COMPUTE: if (cnt == 4'd11) state_nxt = UNLOAD;
      UNLOAD:  if (out_valid && out_ready && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      for (int i = 0; i < 8; i++) begin
        mem_r[i] <= '0;
        mem_i[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          mem_r[{cnt[0], cnt[1], cnt[2]}] <= in_real;
          mem_i[{cnt[0], cnt[1], cnt[2]}] <= in_imag;
          cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
        end
        COMPUTE: begin
          mem_r[pa] <= np_r;
          mem_i[pa] <= np_i;
          mem_r[qa] <= nq_r;
          mem_i[qa] <= nq_i;
          cnt <= (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
        end
        UNLOAD: begin
          // first UNLOAD cycle primes the output register with sample 0
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_index <= 3'd0;
            out_last  <= 1'b0;
            out_real  <= mem_r[0];
            out_imag  <= mem_i[0];
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_index <= nxt_idx;
              out_last  <= (nxt_idx == 3'd7);
              out_real  <= mem_r[nxt_idx];
              out_imag  <= mem_i[nxt_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft8_serial.sv
// Self-checking bench for ifft8_serial: bit-exact stage model plus floating DFT cross-check.
module tb_ifft8_serial;
  localparam int DW = 16;
`ifdef IFFT_STAGE_SCALE_EN
  localparam bit SCALED = 1'b1;
`else
  localparam bit SCALED = 1'b0;
`endif
  typedef int frame_t [8];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy;
  logic signed [DW-1:0] in_real = '0, in_imag = '0, out_real, out_imag;
  logic [2:0] out_index;
  int checks = 0, errors = 0;

  ifft8_serial #(.DATA_W(DW), .TW_FRAC(14)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: bit-reversed load, then 3 stages x 4 butterflies using the textbook index rules.
  task automatic model(input frame_t ar, input frame_t ai, output frame_t yr, output frame_t yi);
    int br[8], bi[8];
    int twr[4] = '{16384, 11585, 0, -11585};
    int twi[4] = '{0, 11585, 16384, 11585};
    for (int k = 0; k < 8; k++) begin
      int r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      br[r] = ar[k];
      bi[r] = ai[k];
    end
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 4; b++) begin
        int h = 1 << s;
        int j = b % h;
        int p = (b / h) * 2 * h + j;
        int q = p + h;
        int m = j * (4 >> s);
        int tr = sat16((br[q] * twr[m] - bi[q] * twi[m] + 8192) >>> 14);
        int ti = sat16((br[q] * twi[m] + bi[q] * twr[m] + 8192) >>> 14);
        int sr = br[p] + tr, si = bi[p] + ti, dr = br[p] - tr, di = bi[p] - ti;
        if (SCALED) begin
          br[p] = sr >>> 1; bi[p] = si >>> 1; br[q] = dr >>> 1; bi[q] = di >>> 1;
        end else begin
          br[p] = sat16(sr); bi[p] = sat16(si); br[q] = sat16(dr); bi[q] = sat16(di);
        end
      end
    yr = br;
    yi = bi;
  endtask

  task automatic send_frame(input frame_t ar, input frame_t ai, input bit gaps, input bit keep_valid);
    int k = 0, guard = 0;
    bit acc;
    while (k < 8 && guard < 200) begin
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_real = DW'(ar[k]);
      in_imag = DW'(ai[k]);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    in_valid = keep_valid;
  endtask

  task automatic recv_frame(input int hold_n, input int hold_cyc, input bit rnd_ready,
                            output frame_t yr, output frame_t yi, output frame_t ix, output frame_t ls,
                            output int hold_bad, output int lat, output bit timeout);
    int n = 0, guard = 0, held = 0;
    logic signed [DW-1:0] sr = '0, si = '0;
    logic [2:0] sx = '0;
    hold_bad = 0;
    lat = 0;
    yr = '{default: 0}; yi = '{default: 0}; ix = '{default: -1}; ls = '{default: -1};
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    while (n < 8 && guard < 400) begin
      if (out_valid && int'(out_index) == hold_n && held < hold_cyc) begin
        if (held == 0) begin
          sr = out_real; si = out_imag; sx = out_index;
        end else if (out_real !== sr || out_imag !== si || out_index !== sx || out_valid !== 1'b1)
          hold_bad++;
        out_ready = 1'b0;
        held++;
      end else
        out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        yr[n] = int'(out_real); yi[n] = int'(out_imag);
        ix[n] = int'(out_index); ls[n] = int'(out_last);
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    timeout = (lat >= 100) || (n < 8);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready_busy: got in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL reset_valid_last: got %b %b, expected 0 0", out_valid, out_last);
    end
    checks++;
    if (out_real !== 0 || out_imag !== 0 || out_index !== 0) begin
      errors++; $display("FAIL reset_outputs: got %0d %0d %0d, expected 0 0 0", out_real, out_imag, out_index);
    end
  endtask

  task automatic test_dc(input string name, input bit gaps, input bit stall_valid);
    frame_t ar = '{default: 0}, ai = '{default: 0}, yr, yi, ix, ls;
    int hb, lat, exp_r;
    bit to;
    ar[0] = 8000;
    exp_r = SCALED ? 1000 : 8000;
    send_frame(ar, ai, gaps, stall_valid);
    if (stall_valid) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s_compute_flags: got in_ready=%b busy=%b, expected 0 1", name, in_ready, busy);
      end
    end
    recv_frame(-1, 0, 1'b0, yr, yi, ix, ls, hb, lat, to);
    checks++;
    if (to || lat != 13) begin
      errors++; $display("FAIL %s_latency: got %0d timeout=%0d, expected 13", name, lat, to);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== exp_r || yi[n] !== 0) begin
        errors++; $display("FAIL %s_x%0d: got (%0d,%0d), expected (%0d,0)", name, n, yr[n], yi[n], exp_r);
      end
      checks++;
      if (ix[n] !== n || ls[n] !== int'(n == 7)) begin
        errors++; $display("FAIL %s_index%0d: got idx=%0d last=%0d, expected %0d %0d", name, n, ix[n], ls[n], n, n == 7);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_return: got in_ready=%b out_valid=%b busy=%b, expected 1 0 0", name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_tone;
    frame_t ar = '{default: 0}, ai = '{default: 0}, yr, yi, ix, ls, er, ei;
    int hb, lat, a, d;
    bit to;
    ar[1] = 8192;
    a = SCALED ? 1024 : 8192;
    d = SCALED ? 724 : 5793;
    model(ar, ai, er, ei);
    send_frame(ar, ai, 1'b0, 1'b0);
    recv_frame(-1, 0, 1'b0, yr, yi, ix, ls, hb, lat, to);
    checks++;
    if (to || yr[0] !== a || yi[0] !== 0 || yr[2] !== 0 || yi[2] !== a ||
        yr[4] !== -a || yi[4] !== 0 || yr[6] !== 0 || yi[6] !== -a) begin
      errors++; $display("FAIL tone_axes: got x0=(%0d,%0d) x2=(%0d,%0d) x4=(%0d,%0d) x6=(%0d,%0d), expected amplitude %0d",
                         yr[0], yi[0], yr[2], yi[2], yr[4], yi[4], yr[6], yi[6], a);
    end
    checks++;
    if (to || yr[1] < d - 1 || yr[1] > d + 1 || yi[1] < d - 1 || yi[1] > d + 1) begin
      errors++; $display("FAIL tone_x1: got (%0d,%0d), expected (%0d,%0d) +-1", yr[1], yi[1], d, d);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== er[n] || yi[n] !== ei[n]) begin
        errors++; $display("FAIL tone_model_x%0d: got (%0d,%0d), expected (%0d,%0d)", n, yr[n], yi[n], er[n], ei[n]);
      end
    end
  endtask

  task automatic test_backpressure;
    frame_t ar, ai, yr, yi, ix, ls, er, ei;
    int hb, lat;
    bit to;
    for (int k = 0; k < 8; k++) begin
      ar[k] = int'($urandom_range(0, 4000)) - 2000;
      ai[k] = int'($urandom_range(0, 4000)) - 2000;
    end
    model(ar, ai, er, ei);
    send_frame(ar, ai, 1'b0, 1'b0);
    recv_frame(3, 5, 1'b0, yr, yi, ix, ls, hb, lat, to);
    checks++;
    if (to || hb != 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable cycles timeout=%0d, expected 0", hb, to);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== er[n] || yi[n] !== ei[n] || ix[n] !== n) begin
        errors++; $display("FAIL bp_x%0d: got (%0d,%0d) idx %0d, expected (%0d,%0d) idx %0d", n, yr[n], yi[n], ix[n], er[n], ei[n], n);
      end
    end
  endtask

  task automatic test_reset_mid;
    frame_t ar, ai = '{default: 0};
    for (int k = 0; k < 8; k++) ar[k] = int'($urandom_range(0, 20000)) - 10000;
    send_frame(ar, ai, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got in_ready=%b busy=%b out_valid=%b, expected 1 0 0", in_ready, busy, out_valid);
    end
    test_dc("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    frame_t ar = '{default: 32767}, ai = '{default: 0}, yr, yi, ix, ls, er, ei;
    int hb, lat;
    bit to;
    model(ar, ai, er, ei);
    send_frame(ar, ai, 1'b0, 1'b0);
    recv_frame(-1, 0, 1'b0, yr, yi, ix, ls, hb, lat, to);
    checks++;
    if (to || lat != 13) begin
      errors++; $display("FAIL ovf_latency: got %0d timeout=%0d, expected 13", lat, to);
    end
    if (!SCALED) begin
      checks++;
      if (yr[0] !== 32767 || yi[0] !== 0) begin
        errors++; $display("FAIL ovf_x0: got (%0d,%0d), expected (32767,0)", yr[0], yi[0]);
      end
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (yr[n] !== er[n] || yi[n] !== ei[n]) begin
        errors++; $display("FAIL ovf_x%0d: got (%0d,%0d), expected (%0d,%0d)", n, yr[n], yi[n], er[n], ei[n]);
      end
    end
  endtask

  task automatic test_back_to_back;
    frame_t ar, ai, yr, yi, ix, ls, er, ei;
    int hb, lat;
    bit to;
    real fr, fi, ang;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) begin
        if (f % 2 == 0) begin
          ar[k] = int'($urandom_range(0, 4000)) - 2000;
          ai[k] = int'($urandom_range(0, 4000)) - 2000;
        end else begin
          ar[k] = int'($urandom_range(0, 65535)) - 32768;
          ai[k] = int'($urandom_range(0, 65535)) - 32768;
        end
      end
      model(ar, ai, er, ei);
      send_frame(ar, ai, f[0], 1'b0);
      recv_frame(-1, 0, 1'b1, yr, yi, ix, ls, hb, lat, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL b2b%0d_timeout: got timeout=1, expected 0", f);
      end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (yr[n] !== er[n] || yi[n] !== ei[n] || ix[n] !== n) begin
          errors++; $display("FAIL b2b%0d_x%0d: got (%0d,%0d) idx %0d, expected (%0d,%0d) idx %0d",
                             f, n, yr[n], yi[n], ix[n], er[n], ei[n], n);
        end
        if (f % 2 == 0) begin
          fr = 0.0; fi = 0.0;
          for (int k = 0; k < 8; k++) begin
            ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
            fr += real'(ar[k]) * $cos(ang) - real'(ai[k]) * $sin(ang);
            fi += real'(ar[k]) * $sin(ang) + real'(ai[k]) * $cos(ang);
          end
          if (SCALED) begin
            fr = fr / 8.0; fi = fi / 8.0;
          end
          checks++;
          if ((real'(yr[n]) - fr) > 4.0 || (fr - real'(yr[n])) > 4.0 ||
              (real'(yi[n]) - fi) > 4.0 || (fi - real'(yi[n])) > 4.0) begin
            errors++; $display("FAIL b2b%0d_float_x%0d: got (%0d,%0d), expected (%0.1f,%0.1f) +-4", f, n, yr[n], yi[n], fr, fi);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc("dc", 1'b0, 1'b0);
    test_tone();
    test_backpressure();
    test_dc("stall", 1'b1, 1'b1);
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
